accum_chan: RTL and testbench
=============================

ACCUM_CHAN -- requirements
Module: accum_chan

Interface
REQ-001 Parameter WIDTH, default 32, accumulator and operand width in bits (>=2).
REQ-002 Parameter CHANNELS, default 4, number of independent accumulators (power of 2, >=2); CW = log2(CHANNELS).
REQ-003 Parameter SATURATE, default 0, 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_chan  input  CW  target accumulator index.
REQ-009 in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-010 a  input  WIDTH  unsigned operand.
REQ-011 ci  input  1  carry-in (ADD) / borrow-in (SUB); ignored for LOAD and CLEAR.
REQ-012 out_valid  output  1  result register holds an unconsumed result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 out_chan  output  CW  channel index of the held result.
REQ-015 result  output  WIDTH  new accumulator value after the operation.
REQ-016 co  output  1  carry-out (ADD) / borrow-out (SUB) of the unclamped operation; 0 for LOAD and CLEAR.
REQ-017 ovf_sticky  output  CHANNELS  per-channel sticky overflow flag.

Function
REQ-018 Accept occurs when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, single-entry skid-free output stage).
REQ-019 On accept: LOAD acc[ch]<=a; ADD acc[ch]<=acc[ch]+a+ci; SUB acc[ch]<=acc[ch]-a-ci; CLEAR acc[ch]<=0 and ovf_sticky[ch]<=0.
REQ-020 ADD/SUB are computed at WIDTH+1 bits; bit WIDTH is co (ADD carry, SUB borrow).
REQ-021 With SATURATE=1, ADD with co=1 SHALL store all-ones and SUB with co=1 SHALL store 0; with SATURATE=0 the low WIDTH bits are stored.
REQ-022 ovf_sticky[ch] SHALL set on any accepted ADD/SUB with co=1 and hold until CLEAR on that channel or reset; LOAD does not change it.
REQ-023 Latency: result, co, out_chan and out_valid=1 SHALL appear on the cycle after accept; result equals the value written into acc[ch].
REQ-024 Output register SHALL hold stable while out_valid && !out_ready; it updates only on accept.
REQ-025 If out_valid && out_ready with no accept, out_valid SHALL fall next cycle; with simultaneous accept it stays 1 with the new result (full throughput, one op/cycle).
REQ-026 Back-to-back accepts to the same channel SHALL each see the value written by the previous op (no read-after-write hazard).
REQ-027 Non-addressed channels SHALL be unchanged by an accept.
REQ-028 in_chan, in_op, a, ci are don't-care when in_valid=0; no state changes without accept.

Reset
REQ-029 reset asserted SHALL immediately clear all acc[] to 0, ovf_sticky to 0, out_valid to 0, result to 0, co to 0, out_chan to 0, regardless of clock.
REQ-030 Reset mid-operation SHALL discard any held or in-flight result; in_ready SHALL read 1 while out_valid=0 after reset.
REQ-031 First accept is permitted on the first rising edge after reset deasserts.

Verification
REQ-032 WIDTH=8: LOAD ch0 a=0x10, then ADD ch0 a=0x05 ci=1 -> results 0x10 then 0x16, co=0, each one cycle after accept.
REQ-033 WIDTH=8 SATURATE=0: LOAD ch1 0xF0, ADD a=0x20 ci=0 -> result 0x10, co=1, ovf_sticky[1]=1; SATURATE=1 same stimulus -> result 0xFF, co=1.
REQ-034 SUB ch2 from 0x03 with a=0x05 ci=0 -> SATURATE=0 result 0xFE co=1; SATURATE=1 result 0x00 co=1; subsequent CLEAR ch2 -> result 0, ovf_sticky[2]=0.
REQ-035 Hold out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, result/out_chan stable; release -> queued op proceeds, no loss or duplication.
REQ-036 Interleave ADD ch0/ch3 every cycle with out_ready=1 -> one result per cycle, each channel sum matches model, other channels unchanged.
REQ-037 Assert reset asynchronously between clock edges with out_valid=1 -> outputs and all accumulators read 0 before the next edge; ADD ch0 a=1 afterwards -> result 0x01.

Source files
------------

// File: rtl/accum_chan.sv
// rtl/accum_chan.sv - multi-channel accumulator with registered, backpressured result
module accum_chan #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int CW      = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [1:0]          in_op,
  input  logic [WIDTH-1:0]    a,
  input  logic                ci,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_chan,
  output logic [WIDTH-1:0]    result,
  output logic                co,
  output logic [CHANNELS-1:0] ovf_sticky
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] acc [CHANNELS];
  logic             accept;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_co;

  // A new op may enter whenever the result register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The accumulator file is the only copy of channel state, so back-to-back ops
  // on one channel naturally read the value written by the previous op.
  assign cur   = acc[in_chan];
  assign add_w = {1'b0, cur} + {1'b0, a} + {{WIDTH{1'b0}}, ci};
  assign sub_w = {1'b0, cur} - {1'b0, a} - {{WIDTH{1'b0}}, ci};

  // Pick the write-back value and carry/borrow for the requested op, clamping when saturating.
  always_comb begin
    nxt_val = '0;
    nxt_co  = 1'b0;
    case (in_op)
      OP_LOAD: nxt_val = a;
      OP_ADD: begin
        nxt_co = add_w[WIDTH];
        if (SATURATE != 0 && add_w[WIDTH]) nxt_val = '1;
        else                               nxt_val = add_w[WIDTH-1:0];
      end
      OP_SUB: begin
        nxt_co = sub_w[WIDTH];
        if (SATURATE != 0 && sub_w[WIDTH]) nxt_val = '0;
        else                               nxt_val = sub_w[WIDTH-1:0];
      end
      default: nxt_val = '0;
    endcase
  end

  // Update the addressed accumulator and its sticky overflow flag on accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      ovf_sticky <= '0;
    end else if (accept) begin
      acc[in_chan] <= nxt_val;
      if (in_op == OP_CLEAR) ovf_sticky[in_chan] <= 1'b0;
      else if (nxt_co)       ovf_sticky[in_chan] <= 1'b1;
    end
  end

  // Single-entry result register: load on accept, empty when drained without a refill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      result    <= '0;
      co        <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_chan  <= in_chan;
      result    <= nxt_val;
      co        <= nxt_co;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_chan.sv
// tb/tb_accum_chan.sv - randomized and directed bench for accum_chan, wrap and saturate builds
module tb_accum_chan;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_chan;
  logic [1:0] in_op;
  logic [7:0] a;
  logic       ci;
  logic       out_ready;

  logic       rdy_w, ov_w, co_w, rdy_s, ov_s, co_s;
  logic [1:0] oc_w, oc_s;
  logic [7:0] res_w, res_s;
  logic [3:0] sto_w, sto_s;

  accum_chan #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
    .in_chan(in_chan), .in_op(in_op), .a(a), .ci(ci), .out_valid(ov_w),
    .out_ready(out_ready), .out_chan(oc_w), .result(res_w), .co(co_w), .ovf_sticky(sto_w)
  );

  accum_chan #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
    .in_chan(in_chan), .in_op(in_op), .a(a), .ci(ci), .out_valid(ov_s),
    .out_ready(out_ready), .out_chan(oc_s), .result(res_s), .co(co_s), .ovf_sticky(sto_s)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;

  int         m_w [4];
  int         m_s [4];
  logic [3:0] st_w, st_s;
  logic       e_ov;
  logic [1:0] e_chan;
  logic [7:0] e_res_w, e_res_s;
  logic       e_co_w, e_co_s;
  logic       seen_rdy_w, seen_rdy_s, exp_rdy;

  wire [15:0] obs_w = {ov_w, oc_w, res_w, co_w, sto_w};
  wire [15:0] obs_s = {ov_s, oc_s, res_s, co_s, sto_s};
  wire [15:0] exp_w = {e_ov, e_chan, e_res_w, e_co_w, st_w};
  wire [15:0] exp_s = {e_ov, e_chan, e_res_s, e_co_s, st_s};

  // Plain-integer statement of one operation on an 8-bit accumulator.
  function automatic void step(input int sat, input int acc, input int op, input int av,
                               input int civ, output int nacc, output int c);
    int v;
    c = 0;
    case (op)
      0:       v = av;
      1:       v = acc + av + civ;
      2:       v = acc - av - civ;
      default: v = 0;
    endcase
    if (op == 1 && v > 255) c = 1;
    if (op == 2 && v < 0)   c = 1;
    if (c == 1 && sat == 1) nacc = (op == 1) ? 255 : 0;
    else                    nacc = ((v % 256) + 256) % 256;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 0;
      m_s[i] = 0;
    end
    st_w = '0; st_s = '0; e_ov = 1'b0; e_chan = '0;
    e_res_w = '0; e_res_s = '0; e_co_w = 1'b0; e_co_s = 1'b0;
  endtask

  // Drive one cycle of inputs from a falling edge, advance the model at the rising edge,
  // and return at the next falling edge where outputs are stable.
  task automatic cycle(input bit iv, input int ch, input int op, input int av,
                       input bit civ, input bit ordy);
    int  nw, ns, cw, cs;
    bit  acc_now;
    in_valid = iv; in_chan = ch[1:0]; in_op = op[1:0]; a = av[7:0]; ci = civ; out_ready = ordy;
    #1;
    seen_rdy_w = rdy_w;
    seen_rdy_s = rdy_s;
    exp_rdy    = !e_ov || ordy;
    @(posedge clock);
    acc_now = iv && (!e_ov || ordy);
    if (acc_now) begin
      step(0, m_w[ch], op, av, int'(civ), nw, cw);
      step(1, m_s[ch], op, av, int'(civ), ns, cs);
      m_w[ch] = nw; m_s[ch] = ns;
      e_ov = 1'b1; e_chan = ch[1:0];
      e_res_w = nw[7:0]; e_res_s = ns[7:0];
      e_co_w = cw[0]; e_co_s = cs[0];
      if (op == 3) begin
        st_w[ch] = 1'b0; st_s[ch] = 1'b0;
      end else begin
        if (cw == 1) st_w[ch] = 1'b1;
        if (cs == 1) st_s[ch] = 1'b1;
      end
    end else if (ordy) begin
      e_ov = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    vectors++;
    if (obs_w !== 16'h0 || obs_s !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got wrap=%h sat=%h expected 0000", obs_w, obs_s);
    end
    vectors++;
    if (rdy_w !== 1'b1 || rdy_s !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got wrap=%b sat=%b expected 1", rdy_w, rdy_s);
    end
  endtask

  task automatic test_basic;
    cycle(1, 0, 0, 'h10, 0, 1);
    vectors++;
    if (obs_w !== exp_w || res_w !== 8'h10 || ov_w !== 1'b1) begin
      fails++;
      $display("FAIL basic_load: got %h expected %h (result 10)", obs_w, exp_w);
    end
    cycle(1, 0, 1, 'h05, 1, 1);
    vectors++;
    if (obs_w !== exp_w || obs_s !== exp_s || res_w !== 8'h16 || co_w !== 1'b0) begin
      fails++;
      $display("FAIL basic_add: got wrap=%h sat=%h expected wrap=%h sat=%h (result 16)", obs_w, obs_s, exp_w, exp_s);
    end
  endtask

  task automatic test_overflow;
    cycle(1, 1, 0, 'hF0, 0, 1);
    cycle(1, 1, 1, 'h20, 0, 1);
    vectors++;
    if (obs_w !== exp_w || res_w !== 8'h10 || co_w !== 1'b1 || sto_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_wrap: got %h expected %h (result 10 co 1 sticky1)", obs_w, exp_w);
    end
    vectors++;
    if (obs_s !== exp_s || res_s !== 8'hFF || co_s !== 1'b1 || sto_s[1] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sat: got %h expected %h (result ff co 1 sticky1)", obs_s, exp_s);
    end
  endtask

  task automatic test_sub_clear;
    cycle(1, 2, 0, 'h03, 0, 1);
    cycle(1, 2, 2, 'h05, 0, 1);
    vectors++;
    if (obs_w !== exp_w || res_w !== 8'hFE || co_w !== 1'b1 || sto_w[2] !== 1'b1) begin
      fails++;
      $display("FAIL sub_wrap: got %h expected %h (result fe co 1)", obs_w, exp_w);
    end
    vectors++;
    if (obs_s !== exp_s || res_s !== 8'h00 || co_s !== 1'b1 || sto_s[2] !== 1'b1) begin
      fails++;
      $display("FAIL sub_sat: got %h expected %h (result 00 co 1)", obs_s, exp_s);
    end
    cycle(1, 2, 3, 'h77, 1, 1);
    vectors++;
    if (obs_w !== exp_w || obs_s !== exp_s || res_w !== 8'h00 || sto_w[2] !== 1'b0 || sto_s[2] !== 1'b0) begin
      fails++;
      $display("FAIL clear: got wrap=%h sat=%h expected wrap=%h sat=%h", obs_w, obs_s, exp_w, exp_s);
    end
  endtask

  task automatic test_backpressure;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 3, 0, 'h55, 0, 0);
    vectors++;
    if (obs_w !== exp_w || res_w !== 8'h55 || oc_w !== 2'd3) begin
      fails++;
      $display("FAIL bp_first: got %h expected %h", obs_w, exp_w);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 1, 'h07, 1, 0);
      vectors++;
      if (seen_rdy_w !== 1'b0 || seen_rdy_s !== 1'b0 || obs_w !== exp_w || obs_s !== exp_s
          || res_w !== 8'h55 || oc_w !== 2'd3) begin
        fails++;
        $display("FAIL bp_hold%0d: got rdy=%b out=%h expected rdy=0 out=%h", i, seen_rdy_w, obs_w, exp_w);
      end
    end
    cycle(1, 2, 1, 'h07, 1, 1);
    vectors++;
    if (seen_rdy_w !== 1'b1 || obs_w !== exp_w || obs_s !== exp_s || oc_w !== 2'd2 || res_w !== 8'h08) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b out=%h expected rdy=1 out=%h", seen_rdy_w, obs_w, exp_w);
    end
    cycle(0, 2, 1, 'h07, 1, 1);
    vectors++;
    if (ov_w !== 1'b0 || ov_s !== 1'b0 || obs_w !== exp_w) begin
      fails++;
      $display("FAIL bp_drain: got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_interleave;
    for (int i = 0; i < 16; i++) begin
      cycle(1, (i % 2 == 0) ? 0 : 3, 1, $urandom_range(0, 255), bit'($urandom_range(0, 1)), 1);
      vectors++;
      if (seen_rdy_w !== 1'b1 || ov_w !== 1'b1 || obs_w !== exp_w || obs_s !== exp_s) begin
        fails++;
        $display("FAIL interleave%0d: got wrap=%h sat=%h expected wrap=%h sat=%h", i, obs_w, obs_s, exp_w, exp_s);
      end
    end
    for (int ch = 1; ch <= 2; ch++) begin
      cycle(1, ch, 1, 0, 0, 1);
      vectors++;
      if (obs_w !== exp_w || obs_s !== exp_s) begin
        fails++;
        $display("FAIL untouched_ch%0d: got wrap=%h sat=%h expected wrap=%h sat=%h", ch, obs_w, obs_s, exp_w, exp_s);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 255), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
      vectors++;
      if (seen_rdy_w !== exp_rdy || seen_rdy_s !== exp_rdy || obs_w !== exp_w || obs_s !== exp_s) begin
        fails++;
        $display("FAIL random%0d: got rdy=%b wrap=%h sat=%h expected rdy=%b wrap=%h sat=%h",
                 i, seen_rdy_w, obs_w, obs_s, exp_rdy, exp_w, exp_s);
      end
    end
  endtask

  task automatic test_async_reset;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 2, 0, 'hA5, 0, 0);
    vectors++;
    if (ov_w !== 1'b1 || res_w !== 8'hA5) begin
      fails++;
      $display("FAIL arst_setup: got %h expected %h", obs_w, exp_w);
    end
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    model_reset;
    #1;
    vectors++;
    if (obs_w !== 16'h0 || obs_s !== 16'h0 || rdy_w !== 1'b1 || rdy_s !== 1'b1) begin
      fails++;
      $display("FAIL arst_immediate: got wrap=%h sat=%h rdy=%b expected 0000 rdy=1", obs_w, obs_s, rdy_w);
    end
    #1;
    reset = 1'b0;
    @(negedge clock);
    cycle(1, 0, 1, 1, 0, 1);
    vectors++;
    if (res_w !== 8'h01 || res_s !== 8'h01 || obs_w !== exp_w || obs_s !== exp_s) begin
      fails++;
      $display("FAIL arst_add: got wrap=%h sat=%h expected result 01", obs_w, obs_s);
    end
    for (int ch = 1; ch < 4; ch++) begin
      cycle(1, ch, 1, 0, 0, 1);
      vectors++;
      if (res_w !== 8'h00 || res_s !== 8'h00 || sto_w !== 4'h0 || sto_s !== 4'h0) begin
        fails++;
        $display("FAIL arst_acc_ch%0d: got wrap=%h sat=%h expected result 00 sticky 0", ch, obs_w, obs_s);
      end
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_op = '0; a = '0; ci = 1'b0; out_ready = 1'b0;
    model_reset;
    @(negedge clock);
    @(negedge clock);
    test_reset;
    reset = 1'b0;
    test_basic;
    test_overflow;
    test_sub_clear;
    test_backpressure;
    test_interleave;
    test_random;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
